// File: rtl/pe_swar_db.sv
`timescale 1ns/1ps
// pe_swar_db: systolic processing element with SIMD-within-a-register MAC.
// Activations flow left->right and weights top->bottom through one register
// stage each. Lane products are summed into a (optionally saturating)
// accumulator. At tile end the result moves into a shadow register that
// belongs to a vertical drain chain, so the next tile starts without a bubble.
module pe_swar_db #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 48,
   parameter int SAT_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_valid,
   output logic [DATA_W-1:0] w_out,
   output logic              w_valid_out,
   input  logic [1:0]        mode,
   input  logic              acc_clear,
   input  logic              drain_shift,
   input  logic [ACC_W-1:0]  drain_in,
   input  logic              drain_vin,
   output logic [ACC_W-1:0]  drain_out,
   output logic              drain_vout,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf,
   output logic              overrun
);

   localparam int N4  = DATA_W / 4;
   localparam int N8  = DATA_W / 8;
   localparam int N16 = DATA_W / 16;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [DATA_W-1:0] r_in_data;
   logic              r_in_valid;
   logic              r_in_last;
   logic [DATA_W-1:0] r_w_data;
   logic              r_w_valid;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_shadow;
   logic              r_shadow_v;
   logic              r_ovf;
   logic              r_overrun;

   logic [ACC_W-1:0]  w_ext4  [N4];
   logic [ACC_W-1:0]  w_ext8  [N8];
   logic [ACC_W-1:0]  w_ext16 [N16];
   logic [ACC_W-1:0]  w_sum4;
   logic [ACC_W-1:0]  w_sum8;
   logic [ACC_W-1:0]  w_sum16;
   logic [ACC_W-1:0]  w_partial;
   logic [ACC_W:0]    w_wide;
   logic              w_ovf_hit;
   logic [ACC_W-1:0]  w_sum_sat;
   logic              w_mac;
   logic              w_capture;
   logic [ACC_W-1:0]  w_capture_val;

   // Forwarding stage: registered every cycle, independent of acc_clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_data  <= '0;
         r_in_valid <= 1'b0;
         r_in_last  <= 1'b0;
         r_w_data   <= '0;
         r_w_valid  <= 1'b0;
      end else begin
         r_in_data  <= in_data;
         r_in_valid <= in_valid;
         r_in_last  <= in_last;
         r_w_data   <= w_data;
         r_w_valid  <= w_valid;
      end
   end

   assign out_data    = r_in_data;
   assign out_valid   = r_in_valid;
   assign out_last    = r_in_last;
   assign w_out       = r_w_data;
   assign w_valid_out = r_w_valid;

   // Lane products. Operands are sign-extended to twice the lane width so the
   // truncated product is exact; results are then sign-extended to ACC_W.
   genvar gi;
   generate
      for (gi = 0; gi < N4; gi++) begin : g_lane4
         logic signed [7:0] w_a;
         logic signed [7:0] w_b;
         logic signed [7:0] w_p;
         assign w_a = 8'(signed'(r_in_data[gi*4 +: 4]));
         assign w_b = 8'(signed'(r_w_data[gi*4 +: 4]));
         assign w_p = w_a * w_b;
         assign w_ext4[gi] = ACC_W'(w_p);
      end
      for (gi = 0; gi < N8; gi++) begin : g_lane8
         logic signed [15:0] w_a;
         logic signed [15:0] w_b;
         logic signed [15:0] w_p;
         assign w_a = 16'(signed'(r_in_data[gi*8 +: 8]));
         assign w_b = 16'(signed'(r_w_data[gi*8 +: 8]));
         assign w_p = w_a * w_b;
         assign w_ext8[gi] = ACC_W'(w_p);
      end
      for (gi = 0; gi < N16; gi++) begin : g_lane16
         logic signed [31:0] w_a;
         logic signed [31:0] w_b;
         logic signed [31:0] w_p;
         assign w_a = 32'(signed'(r_in_data[gi*16 +: 16]));
         assign w_b = 32'(signed'(r_w_data[gi*16 +: 16]));
         assign w_p = w_a * w_b;
         assign w_ext16[gi] = ACC_W'(w_p);
      end
   endgenerate

   // Lane reduction per precision; mode picks one (reserved mode gives 0).
   always_comb begin
      w_sum4  = '0;
      w_sum8  = '0;
      w_sum16 = '0;
      for (int i = 0; i < N4; i++)  w_sum4  = w_sum4  + w_ext4[i];
      for (int i = 0; i < N8; i++)  w_sum8  = w_sum8  + w_ext8[i];
      for (int i = 0; i < N16; i++) w_sum16 = w_sum16 + w_ext16[i];
      case (mode)
         2'd0:    w_partial = w_sum4;
         2'd1:    w_partial = w_sum8;
         2'd2:    w_partial = w_sum16;
         default: w_partial = '0;
      endcase
   end

   // One extra bit exposes signed overflow of accumulator + partial.
   assign w_wide    = {r_acc[ACC_W-1], r_acc} + {w_partial[ACC_W-1], w_partial};
   assign w_ovf_hit = (SAT_EN != 0) && (w_wide[ACC_W] ^ w_wide[ACC_W-1]);
   assign w_sum_sat = w_ovf_hit ? (w_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                                : w_wide[ACC_W-1:0];

   assign w_mac         = r_in_valid & r_w_valid & ~acc_clear;
   assign w_capture     = r_in_last & ~acc_clear;
   assign w_capture_val = w_mac ? w_sum_sat : r_acc;

   // Accumulator: clear beats capture beats MAC; capture restarts from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (acc_clear || w_capture) begin
         r_acc <= '0;
      end else if (w_mac) begin
         r_acc <= w_sum_sat;
      end
   end

   // Sticky flags, both cleared by acc_clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf     <= 1'b0;
         r_overrun <= 1'b0;
      end else if (acc_clear) begin
         r_ovf     <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_mac && w_ovf_hit) r_ovf <= 1'b1;
         if (w_capture && (drain_shift || r_shadow_v)) r_overrun <= 1'b1;
      end
   end

   // Shadow/drain stage: capture wins over shift; acc_clear freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow   <= '0;
         r_shadow_v <= 1'b0;
      end else if (!acc_clear) begin
         if (w_capture) begin
            r_shadow   <= w_capture_val;
            r_shadow_v <= 1'b1;
         end else if (drain_shift) begin
            r_shadow   <= drain_in;
            r_shadow_v <= drain_vin;
         end
      end
   end

   assign acc_out    = r_acc;
   assign drain_out  = r_shadow;
   assign drain_vout = r_shadow_v;
   assign ovf        = r_ovf;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_pe_swar_db.sv
`timescale 1ns/1ps
// Testbench for pe_swar_db (DATA_W=16, ACC_W=40, saturating).
module tb_pe_swar_db;
   localparam int DW = 16;
   localparam int AW = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data, w_data, out_data, w_out;
   logic          in_valid, in_last, w_valid, out_valid, out_last, w_valid_out;
   logic [1:0]    mode;
   logic          acc_clear, drain_shift, drain_vin, drain_vout, ovf, overrun;
   logic [AW-1:0] drain_in, drain_out, acc_out;

   int total = 0;
   int bad   = 0;

   pe_swar_db #(.DATA_W(DW), .ACC_W(AW), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .w_data(w_data), .w_valid(w_valid), .w_out(w_out), .w_valid_out(w_valid_out),
      .mode(mode), .acc_clear(acc_clear), .drain_shift(drain_shift),
      .drain_in(drain_in), .drain_vin(drain_vin), .drain_out(drain_out),
      .drain_vout(drain_vout), .acc_out(acc_out), .ovf(ovf), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference: dot product of signed lanes computed with plain integer math.
   function automatic longint dot(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
      longint s = 0;
      longint x, y, lw;
      if (m == 2'd3) return 0;
      lw = (m == 2'd0) ? 4 : (m == 2'd1) ? 8 : 16;
      for (int i = 0; i < 16 / lw; i++) begin
         x = (longint'(a) >> (i * lw)) % (64'sd1 <<< lw);
         y = (longint'(b) >> (i * lw)) % (64'sd1 <<< lw);
         if (x >= (64'sd1 <<< (lw - 1))) x = x - (64'sd1 <<< lw);
         if (y >= (64'sd1 <<< (lw - 1))) y = y - (64'sd1 <<< lw);
         s = s + x * y;
      end
      return s;
   endfunction

   function automatic longint sat40(input longint v);
      if (v > (64'sd1 <<< 39) - 1) return (64'sd1 <<< 39) - 1;
      if (v < -(64'sd1 <<< 39)) return -(64'sd1 <<< 39);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic wv, input logic last,
                        input logic [15:0] a, input logic [15:0] b);
      in_valid = iv; w_valid = wv; in_last = last; in_data = a; w_data = b;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic clear_acc();
      idle();
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
   endtask

   task automatic test_reset();
      logic [AW*3+DW*2+7:0] all_out;
      #2;
      all_out = {out_data, out_valid, out_last, w_out, w_valid_out, acc_out,
                 drain_out, drain_vout, ovf, overrun};
      total++;
      if (all_out !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      total++;
      if (acc_out !== '0) begin
         bad++; $display("FAIL reset_acc: got %h want 0", acc_out);
      end
      $display("test_reset done");
   endtask

   task automatic test_int8();
      mode = 2'd1;
      clear_acc();
      drive(1'b1, 1'b1, 1'b0, 16'h7F80, 16'h7F80);
      tick();
      total++;
      if ({out_data, out_valid, w_out, w_valid_out} !== {16'h7F80, 1'b1, 16'h7F80, 1'b1}) begin
         bad++; $display("FAIL int8_forward: got %h/%b %h/%b want 7f80/1 7f80/1",
                         out_data, out_valid, w_out, w_valid_out);
      end
      idle();
      tick();
      total++;
      if (acc_out !== 40'd32513) begin
         bad++; $display("FAIL int8_acc: got %0d want 32513", $signed(acc_out));
      end
      total++;
      if (ovf !== 1'b0) begin
         bad++; $display("FAIL int8_ovf: got %b want 0", ovf);
      end
      $display("test_int8 acc=%0d", $signed(acc_out));
   endtask

   task automatic test_int4();
      longint e;
      logic [AW-1:0] rnd;
      mode = 2'd0;
      clear_acc();
      drive(1'b1, 1'b1, 1'b0, 16'hF0F1, 16'h1111); tick();
      drive(1'b1, 1'b1, 1'b0, 16'hF0F1, 16'h1111); tick();
      drive(1'b1, 1'b1, 1'b1, 16'hF0F1, 16'h1111); tick();
      e = -2;
      total++;
      if (acc_out !== e[AW-1:0] || drain_vout !== 1'b0) begin
         bad++; $display("FAIL int4_pre_capture: got acc=%0d v=%b want -2 v=0",
                         $signed(acc_out), drain_vout);
      end
      idle(); tick();
      e = -3;
      total++;
      if (drain_out !== e[AW-1:0] || drain_vout !== 1'b1) begin
         bad++; $display("FAIL int4_shadow: got %0d v=%b want -3 v=1",
                         $signed(drain_out), drain_vout);
      end
      total++;
      if (acc_out !== '0) begin
         bad++; $display("FAIL int4_acc_after_capture: got %0d want 0", $signed(acc_out));
      end
      rnd = {$urandom, $urandom};
      drain_in = rnd; drain_vin = 1'b0; drain_shift = 1'b1;
      tick();
      drain_shift = 1'b0;
      total++;
      if (drain_out !== rnd || drain_vout !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL int4_drain_shift: got %h v=%b ovr=%b want %h v=0 ovr=0",
                         drain_out, drain_vout, overrun, rnd);
      end
      drain_in = '0;
      $display("test_int4 shadow=-3 drained");
   endtask

   task automatic test_sat();
      longint e, p;
      mode = 2'd2;
      clear_acc();
      p = dot(2'd2, 16'h7FFF, 16'h7FFF);
      drive(1'b1, 1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
      for (int k = 1; k <= 600; k++) begin
         tick();
         if (k == 101) begin
            e = 100 * p;
            total++;
            if (acc_out !== e[AW-1:0] || ovf !== 1'b0) begin
               bad++; $display("FAIL sat_partway: got %0d ovf=%b want %0d ovf=0",
                               $signed(acc_out), ovf, e);
            end
         end
      end
      idle(); tick(); tick();
      e = (64'sd1 <<< 39) - 1;
      total++;
      if (acc_out !== e[AW-1:0] || ovf !== 1'b1) begin
         bad++; $display("FAIL sat_max: got %0d ovf=%b want %0d ovf=1", $signed(acc_out), ovf, e);
      end
      drive(1'b1, 1'b1, 1'b0, 16'h8000, 16'h7FFF);
      for (int k = 0; k < 1100; k++) tick();
      idle(); tick(); tick();
      e = -(64'sd1 <<< 39);
      total++;
      if (acc_out !== e[AW-1:0] || ovf !== 1'b1) begin
         bad++; $display("FAIL sat_min: got %0d ovf=%b want %0d ovf=1", $signed(acc_out), ovf, e);
      end
      clear_acc();
      total++;
      if (acc_out !== '0 || ovf !== 1'b0) begin
         bad++; $display("FAIL sat_clear: got %0d ovf=%b want 0 ovf=0", $signed(acc_out), ovf);
      end
      $display("test_sat done");
   endtask

   task automatic test_random_mac();
      longint sum;
      logic [15:0] a, b;
      logic iv, wv;
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         clear_acc();
         sum = 0;
         for (int c = 0; c < 30; c++) begin
            a = 16'($urandom); b = 16'($urandom);
            iv = 1'($urandom); wv = 1'($urandom);
            drive(iv, wv, 1'b0, a, b);
            tick();
            total++;
            if (out_data !== a || w_out !== b || out_valid !== iv || w_valid_out !== wv) begin
               bad++; $display("FAIL rand_forward: got %h %h %b %b want %h %h %b %b",
                               out_data, w_out, out_valid, w_valid_out, a, b, iv, wv);
            end
            if (iv && wv) sum = sat40(sum + dot(2'(m), a, b));
         end
         idle(); tick(); tick();
         total++;
         if (acc_out !== sum[AW-1:0] || ovf !== 1'b0) begin
            bad++; $display("FAIL rand_acc mode%0d: got %0d want %0d", m, $signed(acc_out), sum);
         end
         $display("test_random_mac mode=%0d acc=%0d", m, sum);
      end
   endtask

   task automatic test_back_to_back();
      localparam int T = 6;
      longint exp_t [T];
      logic [1:0] tmode [T];
      logic [15:0] a, b;
      int t;
      for (int i = 0; i < T; i++) begin
         exp_t[i] = 0;
         tmode[i] = 2'($urandom_range(0, 2));
      end
      clear_acc();
      for (int c = 0; c < 4 * T + 3; c++) begin
         if (c < 4 * T) begin
            a = 16'($urandom); b = 16'($urandom);
            drive(1'b1, 1'b1, (c % 4) == 3, a, b);
            exp_t[c / 4] = sat40(exp_t[c / 4] + dot(tmode[c / 4], a, b));
         end else begin
            idle();
         end
         // mode applies to the pair driven in the previous cycle
         mode = (c >= 1 && c - 1 < 4 * T) ? tmode[(c - 1) / 4] : 2'd0;
         drain_shift = (c >= 5) && ((c - 5) % 4 == 0) && ((c - 5) / 4 < T);
         if (drain_shift) begin
            t = (c - 5) / 4;
            total++;
            if (drain_out !== exp_t[t][AW-1:0] || drain_vout !== 1'b1 || acc_out !== '0) begin
               bad++; $display("FAIL b2b_tile%0d: got %0d v=%b acc=%0d want %0d v=1 acc=0",
                               t, $signed(drain_out), drain_vout, $signed(acc_out), exp_t[t]);
            end
            $display("b2b tile %0d mode=%0d result=%0d", t, tmode[t], $signed(drain_out));
         end
         tick();
      end
      drain_shift = 1'b0;
      total++;
      if (overrun !== 1'b0 || drain_vout !== 1'b0) begin
         bad++; $display("FAIL b2b_overrun: got ovr=%b v=%b want ovr=0 v=0", overrun, drain_vout);
      end
   endtask

   task automatic test_overrun();
      logic [15:0] a1, b1, a2, b2, a3, b3;
      longint ea, eb, ec;
      mode = 2'd1;
      clear_acc();
      a1 = 16'($urandom); b1 = 16'($urandom);
      a2 = 16'($urandom); b2 = 16'($urandom);
      a3 = 16'($urandom); b3 = 16'($urandom);
      ea = dot(2'd1, a1, b1); eb = dot(2'd1, a2, b2); ec = dot(2'd1, a3, b3);
      drive(1'b1, 1'b1, 1'b1, a1, b1); tick();
      drive(1'b1, 1'b1, 1'b1, a2, b2); tick();
      total++;
      if (drain_out !== ea[AW-1:0] || drain_vout !== 1'b1 || overrun !== 1'b0) begin
         bad++; $display("FAIL ovr_first: got %0d v=%b ovr=%b want %0d v=1 ovr=0",
                         $signed(drain_out), drain_vout, overrun, ea);
      end
      idle(); tick();
      total++;
      if (drain_out !== eb[AW-1:0] || overrun !== 1'b1) begin
         bad++; $display("FAIL ovr_overwrite: got %0d ovr=%b want %0d ovr=1",
                         $signed(drain_out), overrun, eb);
      end
      clear_acc();
      total++;
      if (overrun !== 1'b0 || drain_out !== eb[AW-1:0] || drain_vout !== 1'b1) begin
         bad++; $display("FAIL ovr_clear_keeps_shadow: got ovr=%b %0d v=%b want ovr=0 %0d v=1",
                         overrun, $signed(drain_out), drain_vout, eb);
      end
      drive(1'b1, 1'b1, 1'b1, a3, b3); tick();
      idle();
      drain_in = {$urandom, $urandom}; drain_vin = 1'b1; drain_shift = 1'b1;
      tick();
      drain_shift = 1'b0;
      total++;
      if (drain_out !== ec[AW-1:0] || overrun !== 1'b1) begin
         bad++; $display("FAIL ovr_capture_wins: got %0d ovr=%b want %0d ovr=1",
                         $signed(drain_out), overrun, ec);
      end
      drain_in = '0; drain_vin = 1'b0; drain_shift = 1'b1;
      tick();
      drain_shift = 1'b0;
      clear_acc();
      $display("test_overrun done");
   endtask

   task automatic test_reset_mid();
      logic [AW*3+DW*2+7:0] all_out;
      longint e;
      mode = 2'd1;
      clear_acc();
      drive(1'b1, 1'b1, 1'b1, 16'h7F7F, 16'h0101); tick();
      drive(1'b1, 1'b1, 1'b0, 16'h7F7F, 16'h0101); tick();
      drive(1'b1, 1'b1, 1'b0, 16'h7F7F, 16'h0101); tick();
      tick();
      e = 508;
      total++;
      if (acc_out !== e[AW-1:0] || drain_vout !== 1'b1) begin
         bad++; $display("FAIL mid_pre: got %0d v=%b want 508 v=1", $signed(acc_out), drain_vout);
      end
      #2 rst_n = 1'b0;
      #1;
      all_out = {out_data, out_valid, out_last, w_out, w_valid_out, acc_out,
                 drain_out, drain_vout, ovf, overrun};
      total++;
      if (all_out !== '0) begin
         bad++; $display("FAIL mid_reset_async: got %h want 0", all_out);
      end
      idle();
      #2 rst_n = 1'b1;
      tick();
      drive(1'b1, 1'b1, 1'b0, 16'h7F7F, 16'h0101); tick();
      idle(); tick();
      e = 254;
      total++;
      if (acc_out !== e[AW-1:0] || drain_vout !== 1'b0) begin
         bad++; $display("FAIL mid_first_mac: got %0d v=%b want 254 v=0", $signed(acc_out), drain_vout);
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst_n = 1'b0;
      mode = 2'd0; acc_clear = 1'b0; drain_shift = 1'b0;
      drain_in = '0; drain_vin = 1'b0;
      idle();
      test_reset();
      test_int8();
      test_int4();
      test_sat();
      test_random_mac();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pe_swar_db.md
PE_SWAR_DB -- requirements
Module: pe_swar_db

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning packed operand width; legal values are multiples of 16.
REQ-002 The block SHALL have parameter ACC_W, default 48, meaning accumulator/drain width; legal values are at least 2*16+8.
REQ-003 The block SHALL have parameter SAT_EN, default 1, meaning 1 selects saturating accumulation and 0 selects wrap-around accumulation.
REQ-004 The block SHALL have ports: clk in 1 (clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-005 The block SHALL have ports: in_data in DATA_W; in_valid in 1; in_last in 1 (horizontal activation stream from left).
REQ-006 The block SHALL have ports: out_data out DATA_W; out_valid out 1; out_last out 1 (registered horizontal forward to right).
REQ-007 The block SHALL have ports: w_data in DATA_W; w_valid in 1 (weight stream from top); w_out out DATA_W; w_valid_out out 1 (registered vertical forward to bottom).
REQ-008 The block SHALL have ports: mode in 2, encoded 0=INT4, 1=INT8, 2=INT16, 3=reserved.
REQ-009 The block SHALL have ports: acc_clear in 1 (synchronous accumulator clear); drain_shift in 1 (advance drain chain).
REQ-010 The block SHALL have ports: drain_in in ACC_W; drain_vin in 1 (from PE above); drain_out out ACC_W; drain_vout out 1 (shadow result to PE below).
REQ-011 The block SHALL have ports: acc_out out ACC_W (live accumulator); ovf out 1 (sticky saturation flag); overrun out 1 (sticky result-lost flag).

Function
REQ-012 The block SHALL register in_data/in_valid/in_last and w_data/w_valid every cycle unconditionally, and drive out_* and w_out/w_valid_out from these registers, giving 1-cycle forward latency.
REQ-013 A MAC SHALL occur on cycles where the registered in_valid and w_valid are both 1 and acc_clear=0.
REQ-014 The operands SHALL be split into signed lanes: INT4 gives DATA_W/4 lanes of 4b, INT8 gives DATA_W/8 lanes of 8b, and INT16 gives DATA_W/16 lanes of 16b, with lane 0 at the LSBs.
REQ-015 The partial sum SHALL be the sum of lane-wise signed products, sign-extended to ACC_W.
REQ-016 mode=3 SHALL yield a partial sum of 0.
REQ-017 mode SHALL be sampled combinationally on the MAC cycle, and a mode change mid-tile SHALL affect only subsequent MACs.
REQ-018 With SAT_EN=1, an accumulate exceeding the signed ACC_W range SHALL clamp to max/min and set ovf; with SAT_EN=0 the accumulator SHALL wrap and ovf SHALL remain 0.
REQ-019 Latency SHALL be as follows: an input pair presented at edge N SHALL be reflected in acc_out after edge N+2.
REQ-020 Tile end: on a MAC cycle with registered in_last=1, the shadow register SHALL capture accumulator+partial (saturated per REQ-018) and set the shadow valid flag, and the accumulator SHALL load 0 on the same edge so that the next tile starts without a bubble.
REQ-021 A registered in_last without a MAC SHALL capture the current accumulator and clear it.
REQ-022 drain_out SHALL equal the shadow register and drain_vout SHALL equal the shadow valid flag.
REQ-023 On drain_shift=1 without a capture, the shadow SHALL load drain_in and the shadow valid flag SHALL load drain_vin.
REQ-024 A simultaneous capture and drain_shift SHALL be resolved in favour of the capture, and overrun SHALL be set.
REQ-025 A capture while the shadow valid flag is 1 and drain_shift=0 SHALL overwrite the shadow and set overrun.
REQ-026 acc_clear SHALL have highest priority: it zeroes the accumulator, discards that cycle's MAC and capture, and clears ovf and overrun.
REQ-027 acc_clear SHALL leave the shadow register and shadow valid flag unchanged.
REQ-028 acc_clear SHALL NOT block forwarding of out_* or w_out.

Reset
REQ-029 On rst_n low, all registers SHALL asynchronously reset to 0: out_data, out_valid, out_last, w_out, w_valid_out, acc_out, drain_out, drain_vout, ovf, and overrun.
REQ-030 Reset mid-tile SHALL discard partial accumulation and shadow contents.
REQ-031 The first MAC after reset release SHALL accumulate from 0.

Verification
REQ-032 The bench SHALL cover: INT8, DATA_W=16, in=0x7F80, w=0x7F80 valid 1 cycle -> acc_out=127*127+(-128*-128)=32513 two edges later.
REQ-033 The bench SHALL cover: INT4, in=0xF0F1, w=0x1111, 3 valid cycles then last -> shadow=3*(1+(-1)+0+(-1))=-3, drain_vout=1, and acc_out=0 on the capture edge.
REQ-034 The bench SHALL cover: ACC_W=40, SAT_EN=1, INT16, repeated 0x7FFF*0x7FFF -> acc_out pins at 2^39-1 and ovf=1; acc_clear -> acc_out=0 and ovf=0.
REQ-035 The bench SHALL cover: back-to-back tiles with last every 4 cycles and drain_shift asserted the cycle after each capture -> no overrun, and each drain_out value matches the reference dot product.
REQ-036 The bench SHALL cover: capture while shadow valid and drain_shift=0 -> overrun=1 and shadow holds the new tile result; simultaneous capture and drain_shift -> capture wins and overrun=1.
REQ-037 The bench SHALL cover: rst_n asserted mid-tile with acc_out≠0 -> all outputs 0 immediately, with no clock edge required.
